// File: rtl/down_timer_pkg.sv
// Shared types and default sizing for the down_timer block.
package down_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH    = 4;
   localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle of the down_timer: load, enables, terminal-count and status flags.
interface down_timer_if
   import down_timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             ld;
   logic [WIDTH-1:0] loadin;
   logic             ce;
   logic             auto_rl;
   logic             oe;
   logic             tc;
   logic             busy;
   logic             done;

   modport master (
      output ld, loadin, ce, auto_rl, oe,
      input  tc, busy, done
   );

   modport slave (
      input  ld, loadin, ce, auto_rl, oe,
      output tc, busy, done
   );

endinterface

// File: rtl/down_timer_prescaler.sv
// Modulo-PRESCALE tick generator for the down_timer; only built when DOWN_TIMER_PRESCALE_EN is defined.
`ifdef DOWN_TIMER_PRESCALE_EN
module down_timer_prescaler
   import down_timer_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int          PW   = $clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] ps_q;
   logic [PW-1:0] ps_d;
   logic          at_last;

   assign at_last = (ps_q == LAST);
   // The tick coincides with the wrap back to 0; a clear suppresses it.
   assign tick    = en && !clr && at_last;

   always_comb begin
      ps_d = ps_q;
      if (clr) begin
         ps_d = '0;
      end else if (en) begin
         ps_d = at_last ? '0 : ps_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q <= '0;
      end else begin
         ps_q <= ps_d;
      end
   end

endmodule
`endif

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-cycle terminal-count pulse, optional auto-reload and tri-state readout.
// Optional count prescaler selected by DOWN_TIMER_PRESCALE_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no period loaded (or zero loaded); cnt holds, ce ignored
// RUN   | counting toward the terminal tick; busy high
// DONE  | terminal tick reached without auto-reload; cnt=0, done high
module down_timer
   import down_timer_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             rst_n,
   down_timer_if.slave      bus,
   output tri   [WIDTH-1:0] dout
);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH-1:0] rld_q;
   logic [WIDTH-1:0] rld_d;
   logic             tc_q;
   logic             tc_d;
   logic             busy_q;
   logic             done_q;
   logic             run_en;
   logic             tick;

   assign run_en = (state_q == RUN) && bus.ce;

`ifdef DOWN_TIMER_PRESCALE_EN
   down_timer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.ld),
      .en    (run_en),
      .tick  (tick)
   );
`else
   assign tick = run_en;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rld_d   = rld_q;
      tc_d    = 1'b0;
      if (bus.ld) begin
         cnt_d   = bus.loadin;
         rld_d   = bus.loadin;
         state_d = (bus.loadin != '0) ? RUN : IDLE;
      end else begin
         unique case (state_q)
            IDLE: ;
            DONE: ;
            RUN: begin
               if (tick) begin
                  if (cnt_q > WIDTH'(1)) begin
                     cnt_d = cnt_q - WIDTH'(1);
                  end else begin
                     // Terminal tick: cnt is 1 here, RUN is never entered with 0.
                     tc_d = 1'b1;
                     if (bus.auto_rl) begin
                        cnt_d = rld_q;
                     end else begin
                        cnt_d   = '0;
                        state_d = DONE;
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rld_q   <= '0;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rld_q   <= rld_d;
         tc_q    <= tc_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

   assign bus.tc   = tc_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

   assign dout = bus.oe ? cnt_q : {WIDTH{1'bz}};

endmodule

// File: doc/down_timer.md
# down_timer

Loadable down-counting timer with terminal-count signalling and a tri-state count readout. It is the counterpart of the team's loadable up-counter: it counts toward zero instead of away from it and reports when it gets there. Software or a controlling FSM loads a period, enables counting, and consumes the one-cycle `tc` pulse. Optional auto-reload makes it a periodic tick generator. The count drives the same shared tri-state bus style as the up-counter.

## Interface
Parameters:
- `WIDTH`, default 4: counter and load width.
- `PRESCALE`, default 4: clock cycles per count tick; used only when `DOWN_TIMER_PRESCALE_EN` is defined; must be ≥ 2.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ld` in 1: load strobe; highest priority.
- `loadin` in WIDTH: period value captured on `ld`.
- `ce` in 1: count enable; counting pauses while low.
- `auto_rl` in 1: auto-reload select; sampled at the terminal tick.
- `oe` in 1: output enable for `dout`.
- `dout` out WIDTH: current count when `oe`=1, otherwise all-Z (combinational).
- `tc` out 1: registered one-cycle terminal-count pulse.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- Internal registers: `cnt` (WIDTH), `rld` (WIDTH), `state` ∈ {IDLE, RUN, DONE}.
- Reset (async, any time, including mid-count):
  - `cnt`=0, `rld`=0, state=IDLE.
  - `tc`=0, `busy`=0, `done`=0.
  - `dout` = 0 if `oe`=1, else Z.
- Load, with `ld`=1 in any state:
  - `cnt`←`loadin` and `rld`←`loadin`.
  - Next state is RUN if `loadin`≠0, else IDLE.
  - `tc`=0 on the following cycle.
  - The prescaler is cleared.
- IDLE: `cnt` holds; `ce` is ignored; leave only via `ld`.
- RUN with a tick (`ce`=1, plus the prescaler tick when configured):
  - If `cnt`>1: `cnt`←`cnt`−1.
  - If `cnt`==1 (terminal tick): `tc`←1 for one cycle, then:
    - `auto_rl`=1: `cnt`←`rld`, remain in RUN.
    - `auto_rl`=0: `cnt`←0, go to DONE.
- RUN with `ce`=0: `cnt` holds, the prescaler holds, no `tc`.
- DONE: `cnt`=0 holds; `ce` is ignored; leave only via `ld`.
- Wrap-around: `cnt` never decrements below 0. No underflow path exists.
- Simultaneous events:
  - `ld` coincident with a terminal tick: the load wins and `tc` is not asserted.
  - An `auto_rl` change is seen only at the terminal tick.
- `oe` has no effect on internal state.

## Timing
- `ld` sampled at edge k → `dout`=`loadin` immediately after edge k.
- With load value N≥1 and `ce` held high from edge k+1, without prescale: `cnt` reaches 1 after edge k+N−1.
- The terminal tick is edge k+N. `tc`=1 for exactly the one cycle after that edge.
- With prescale, each count step takes `PRESCALE` enabled cycles.
- Auto-reload period = N ticks. `tc` pulses every N ticks with no gap cycle.
- `busy` and `done` are registered, derived from state; no combinational path from inputs.
- `dout` is combinational from `cnt` and `oe`.

## Configuration
- `DOWN_TIMER_PRESCALE_EN` defined:
  - A modulo-`PRESCALE` prescaler gates count ticks.
  - It advances only while in RUN with `ce`=1, and clears on `ld` and on reset.
  - A tick occurs when it wraps to 0.
- `DOWN_TIMER_PRESCALE_EN` undefined:
  - Every enabled RUN cycle is a tick.
  - `PRESCALE` is ignored and no prescaler logic is generated.

## Structure
- Shared package `down_timer_pkg`: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default `WIDTH`/`PRESCALE` constants.
- One sub-module, `down_timer_prescaler`:
  - Ports: `clk`, `rst_n`, `clr`, `en`, `tick`.
  - Instantiated only under `DOWN_TIMER_PRESCALE_EN`.
- The top module holds the FSM, the `cnt`/`rld` registers and the tri-state output.

## Test plan
- Reset mid-count (`cnt`=5, RUN), assert `rst_n`=0 asynchronously → immediately `cnt`=0, state IDLE, `tc`=0, `busy`=0; with `oe`=1, `dout`=4'h0.
- Load 4'd3 with `ce`=1, `auto_rl`=0, no prescale → `dout` follows 3,2,1,0; `tc` high for exactly one cycle at 0; then `done`=1; further `ce` leaves `dout`=0.
- Load 4'd2 with `auto_rl`=1 and `ce` high for 8 cycles → `tc` pulses every 2 cycles; `dout` alternates 2,1.
- Load 4'd4 and toggle `ce` 1,0,1,0… → each count step takes 2 cycles; `tc` appears 8 cycles after the load.
- Assert `ld` with 4'd7 on the terminal-tick cycle of a running count → no `tc`; `dout`=7 next; RUN continues. Load 4'd0 → state IDLE, `tc` never asserted.
- `oe`=0 throughout any run → `dout`=4'bzzzz while `tc`/`done` behave identically.
- With `DOWN_TIMER_PRESCALE_EN` and `PRESCALE`=4, load 4'd2 with `ce`=1 → `tc` 8 cycles after the load.
